// File: rtl/pipe_ctrl_fwd.sv
// pipe_ctrl_fwd
// Pipeline control and operand forwarding for the back-end stages behind
// decode. It holds valid/payload/gr_we/dest for NSTAGE stages. Each stage
// moves forward with a ready_go/allowin handshake. Decode sources are
// resolved against the youngest in-flight producer, and decode stalls when
// that producer's result is not final yet.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_*                 decode-side instruction, sources and regfile data
//   in_ready, in_fire    decode may advance / decode instruction is issued
//   stall                data hazard at decode
//   src1_value/src2_value resolved operands
//   st_ready_go          per-stage done
//   st_result            per-stage current result, [k*DW +: DW]
//   st_result_ok         per-stage result is final
//   st_valid, st_payload, st_gr_we, st_dest   stage registers
//   out_allowin          retire sink accepts the last stage
//   flush                kill stages 0..FLUSH_DEPTH-1 and the decode issue
module pipe_ctrl_fwd #(
    parameter int NSTAGE      = 3,
    parameter int DW          = 32,
    parameter int RW          = 5,
    parameter int PW          = 64,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [PW-1:0]        in_payload,
    input  logic                 in_gr_we,
    input  logic [RW-1:0]        in_dest,
    input  logic [RW-1:0]        in_src1,
    input  logic [RW-1:0]        in_src2,
    input  logic                 in_need1,
    input  logic                 in_need2,
    input  logic [DW-1:0]        in_rdata1,
    input  logic [DW-1:0]        in_rdata2,
    output logic                 in_ready,
    output logic                 in_fire,
    output logic                 stall,
    output logic [DW-1:0]        src1_value,
    output logic [DW-1:0]        src2_value,
    input  logic [NSTAGE-1:0]    st_ready_go,
    input  logic [NSTAGE*DW-1:0] st_result,
    input  logic [NSTAGE-1:0]    st_result_ok,
    output logic [NSTAGE-1:0]    st_valid,
    output logic [NSTAGE*PW-1:0] st_payload,
    output logic [NSTAGE-1:0]    st_gr_we,
    output logic [NSTAGE*RW-1:0] st_dest,
    input  logic                 out_allowin,
    input  logic                 flush
);

    logic          valid_q   [NSTAGE];
    logic [PW-1:0] payload_q [NSTAGE];
    logic          gr_we_q   [NSTAGE];
    logic [RW-1:0] dest_q    [NSTAGE];

    logic [NSTAGE:0] allowin;

    logic          feed_valid   [NSTAGE];
    logic [PW-1:0] feed_payload [NSTAGE];
    logic          feed_gr_we   [NSTAGE];
    logic [RW-1:0] feed_dest    [NSTAGE];

    logic [RW-1:0] fwd_src   [2];
    logic [DW-1:0] fwd_rdata [2];
    logic [DW-1:0] fwd_value [2];
    logic          fwd_hz    [2];
    logic          fwd_found;

    // allowin ripples back from the retire sink. It is built in one block
    // so the chain stays a single combinational process.
    always_comb begin
        allowin         = '0;
        allowin[NSTAGE] = out_allowin;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            allowin[k] = !valid_q[k] | (st_ready_go[k] & allowin[k+1]);
        end
    end

    assign fwd_src[0]   = in_src1;
    assign fwd_src[1]   = in_src2;
    assign fwd_rdata[0] = in_rdata1;
    assign fwd_rdata[1] = in_rdata2;

    // Only the youngest matching producer counts. An unfinished youngest
    // match is a hazard even when an older stage has a final value.
    always_comb begin
        fwd_found = 1'b0;
        for (int j = 0; j < 2; j++) begin
            fwd_value[j] = fwd_rdata[j];
            fwd_hz[j]    = 1'b0;
            fwd_found    = 1'b0;
            for (int k = 0; k < NSTAGE; k++) begin
                if (!fwd_found && valid_q[k] && gr_we_q[k] &&
                    dest_q[k] == fwd_src[j] && fwd_src[j] != '0) begin
                    fwd_found = 1'b1;
                    if (st_result_ok[k]) begin
                        fwd_value[j] = st_result[k*DW +: DW];
                    end else begin
                        fwd_hz[j] = 1'b1;
                    end
                end
            end
        end
    end

    assign src1_value = fwd_value[0];
    assign src2_value = fwd_value[1];
    assign stall      = in_valid & ((in_need1 & fwd_hz[0]) | (in_need2 & fwd_hz[1]));
    assign in_ready   = !stall & allowin[0];
    assign in_fire    = in_valid & in_ready & !flush;

    // What each stage would load. A flush turns the hand-off out of the
    // last flushed stage into a bubble, so nothing flushed leaks onward.
    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            if (k == 0) begin
                feed_valid[k]   = in_fire;
                feed_payload[k] = in_payload;
                feed_gr_we[k]   = in_gr_we;
                feed_dest[k]    = in_dest;
            end else begin
                feed_valid[k]   = valid_q[k-1] & st_ready_go[k-1] &
                                  !(flush && (k - 1 == FLUSH_DEPTH - 1));
                feed_payload[k] = payload_q[k-1];
                feed_gr_we[k]   = gr_we_q[k-1];
                feed_dest[k]    = dest_q[k-1];
            end
        end
    end

    // Stage registers. A flush of the front stages wins over any load or
    // hold. A bubble clears valid but leaves the old payload fields alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                valid_q[k]   <= 1'b0;
                payload_q[k] <= '0;
                gr_we_q[k]   <= 1'b0;
                dest_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                if (flush && k < FLUSH_DEPTH) begin
                    valid_q[k] <= 1'b0;
                end else if (allowin[k]) begin
                    valid_q[k] <= feed_valid[k];
                    if (feed_valid[k]) begin
                        payload_q[k] <= feed_payload[k];
                        gr_we_q[k]   <= feed_gr_we[k];
                        dest_q[k]    <= feed_dest[k];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NSTAGE; g++) begin : g_out
        assign st_valid[g]             = valid_q[g];
        assign st_payload[g*PW +: PW]  = payload_q[g];
        assign st_gr_we[g]             = gr_we_q[g];
        assign st_dest[g*RW +: RW]     = dest_q[g];
    end

endmodule

// File: tb/tb_pipe_ctrl_fwd.sv
// tb_pipe_ctrl_fwd
// Random stimulus against a slot-occupancy reference model of the pipeline
// (NSTAGE=3, FLUSH_DEPTH=2). Stage contents are tracked as an array of
// instruction records. Operand resolution is modelled as "the last writer
// seen when walking from oldest to youngest".
module tb_pipe_ctrl_fwd;

    localparam int NSTAGE = 3;
    localparam int DW     = 32;
    localparam int RW     = 5;
    localparam int PW     = 64;
    localparam int FD     = 2;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic [PW-1:0]        in_payload;
    logic                 in_gr_we;
    logic [RW-1:0]        in_dest;
    logic [RW-1:0]        in_src1;
    logic [RW-1:0]        in_src2;
    logic                 in_need1;
    logic                 in_need2;
    logic [DW-1:0]        in_rdata1;
    logic [DW-1:0]        in_rdata2;
    logic                 in_ready;
    logic                 in_fire;
    logic                 stall;
    logic [DW-1:0]        src1_value;
    logic [DW-1:0]        src2_value;
    logic [NSTAGE-1:0]    st_ready_go;
    logic [NSTAGE*DW-1:0] st_result;
    logic [NSTAGE-1:0]    st_result_ok;
    logic [NSTAGE-1:0]    st_valid;
    logic [NSTAGE*PW-1:0] st_payload;
    logic [NSTAGE-1:0]    st_gr_we;
    logic [NSTAGE*RW-1:0] st_dest;
    logic                 out_allowin;
    logic                 flush;

    pipe_ctrl_fwd #(
        .NSTAGE(NSTAGE), .DW(DW), .RW(RW), .PW(PW), .FLUSH_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_payload(in_payload), .in_gr_we(in_gr_we),
        .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2),
        .in_need1(in_need1), .in_need2(in_need2),
        .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
        .in_ready(in_ready), .in_fire(in_fire), .stall(stall),
        .src1_value(src1_value), .src2_value(src2_value),
        .st_ready_go(st_ready_go), .st_result(st_result),
        .st_result_ok(st_result_ok), .st_valid(st_valid),
        .st_payload(st_payload), .st_gr_we(st_gr_we), .st_dest(st_dest),
        .out_allowin(out_allowin), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [PW-1:0] pl;
        logic          we;
        logic [RW-1:0] dest;
    } stage_t;

    stage_t m [NSTAGE];

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Last writer walking oldest to youngest decides the operand.
    task automatic fwdModel(input logic [RW-1:0] s, input logic [DW-1:0] rd,
                            output logic [DW-1:0] val, output logic hz);
        val = rd;
        hz  = 1'b0;
        if (s != '0) begin
            for (int k = NSTAGE - 1; k >= 0; k--) begin
                if (m[k].v && m[k].we && m[k].dest == s) begin
                    if (st_result_ok[k]) begin
                        val = st_result[k*DW +: DW];
                        hz  = 1'b0;
                    end else begin
                        val = rd;
                        hz  = 1'b1;
                    end
                end
            end
        end
    endtask

    // A slot is vacated when empty or when its occupant leaves; an occupant
    // leaves when done and the slot ahead (or the sink) is vacated.
    task automatic slotModel(output logic [NSTAGE-1:0] leave, output logic [NSTAGE-1:0] vac);
        logic ahead;
        ahead = out_allowin;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            leave[k] = m[k].v & st_ready_go[k] & ahead;
            vac[k]   = !m[k].v | leave[k];
            ahead    = vac[k];
        end
    endtask

    task automatic expectDecode(output logic eStall, output logic eReady, output logic eFire,
                                output logic [DW-1:0] v1, output logic h1,
                                output logic [DW-1:0] v2, output logic h2);
        logic [NSTAGE-1:0] leave, vac;
        slotModel(leave, vac);
        fwdModel(in_src1, in_rdata1, v1, h1);
        fwdModel(in_src2, in_rdata2, v2, h2);
        eStall = in_valid & ((in_need1 & h1) | (in_need2 & h2));
        eReady = !eStall & vac[0];
        eFire  = in_valid & eReady & !flush;
    endtask

    task automatic checkAll();
        logic [NSTAGE-1:0]    ev, ewe;
        logic [NSTAGE*PW-1:0] epl;
        logic [NSTAGE*RW-1:0] edst;
        logic                 eStall, eReady, eFire, h1, h2;
        logic [DW-1:0]        v1, v2;
        for (int k = 0; k < NSTAGE; k++) begin
            ev[k]             = m[k].v;
            ewe[k]            = m[k].we;
            epl[k*PW +: PW]   = m[k].pl;
            edst[k*RW +: RW]  = m[k].dest;
        end
        checkOutput("st_valid", 256'(st_valid), 256'(ev));
        checkOutput("st_payload", 256'(st_payload), 256'(epl));
        checkOutput("st_gr_we", 256'(st_gr_we), 256'(ewe));
        checkOutput("st_dest", 256'(st_dest), 256'(edst));
        expectDecode(eStall, eReady, eFire, v1, h1, v2, h2);
        checkOutput("stall", 256'(stall), 256'(eStall));
        checkOutput("in_ready", 256'(in_ready), 256'(eReady));
        checkOutput("in_fire", 256'(in_fire), 256'(eFire));
        if (!h1) checkOutput("src1_value", 256'(src1_value), 256'(v1));
        if (!h2) checkOutput("src2_value", 256'(src2_value), 256'(v2));
    endtask

    task automatic stepModel();
        logic [NSTAGE-1:0] leave, vac;
        logic              eStall, eReady, eFire, h1, h2, inc;
        logic [DW-1:0]     v1, v2;
        stage_t            nm [NSTAGE];
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) m[k] = '0;
            return;
        end
        slotModel(leave, vac);
        expectDecode(eStall, eReady, eFire, v1, h1, v2, h2);
        for (int k = 0; k < NSTAGE; k++) nm[k] = m[k];
        if (flush) nm[0].v = 1'b0;
        else if (vac[0]) begin
            nm[0].v = eFire;
            if (eFire) begin
                nm[0].pl   = in_payload;
                nm[0].we   = in_gr_we;
                nm[0].dest = in_dest;
            end
        end
        for (int k = 1; k < NSTAGE; k++) begin
            if (flush && k < FD) nm[k].v = 1'b0;
            else if (vac[k]) begin
                inc = leave[k-1] && !(flush && k - 1 == FD - 1);
                nm[k].v = inc;
                if (inc) begin
                    nm[k].pl   = m[k-1].pl;
                    nm[k].we   = m[k-1].we;
                    nm[k].dest = m[k-1].dest;
                end
            end
        end
        for (int k = 0; k < NSTAGE; k++) m[k] = nm[k];
    endtask

    task automatic applyStimulus(input logic quiet);
        reset       = quiet ? 1'b0 : ($urandom_range(0, 59) == 0);
        flush       = quiet ? 1'b0 : ($urandom_range(0, 9) == 0);
        in_valid    = quiet ? 1'b0 : ($urandom_range(0, 9) < 7);
        in_payload  = {$urandom, $urandom};
        in_gr_we    = ($urandom_range(0, 3) != 0);
        in_dest     = RW'($urandom_range(0, 3));
        in_src1     = RW'($urandom_range(0, 3));
        in_src2     = RW'($urandom_range(0, 3));
        in_need1    = ($urandom_range(0, 3) != 0);
        in_need2    = ($urandom_range(0, 1) != 0);
        in_rdata1   = $urandom;
        in_rdata2   = $urandom;
        st_result   = {$urandom, $urandom, $urandom};
        for (int k = 0; k < NSTAGE; k++) begin
            st_ready_go[k]  = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
            st_result_ok[k] = ($urandom_range(0, 1) != 0);
        end
        out_allowin = quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        for (int k = 0; k < NSTAGE; k++) m[k] = '0;
        applyStimulus(1'b1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b1);
        #1;
        $display("[TB] checking reset state");
        checkAll();
        @(posedge clk);
        stepModel();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            applyStimulus(1'b0);
            #1;
            checkAll();
            @(posedge clk);
            stepModel();
        end
        @(negedge clk);
        #1;
        checkAll();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
